// File: rtl/lfsr_stim_ctrl.sv
// lfsr_stim_ctrl: 16-bit Fibonacci LFSR stimulus source with a run controller.
// A run discards WARMUP LFSR steps, then offers num_samples values over a
// valid/ready handshake. The LFSR only advances on warmup steps and accepted
// samples, so its sequence continues across runs until reseeded.
module lfsr_stim_ctrl #(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
  parameter int unsigned WARMUP       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  input  logic [15:0] num_samples,
  input  logic        smp_ready,
  output logic        smp_valid,
  output logic [15:0] smp_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] sample_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Index of the last warmup step; unused when WARMUP is zero.
  localparam logic [7:0] LP_WARM_LAST = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

  // One right-shift step: feedback from taps 0, 2, 3 and 5 enters at bit 15.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by the default.
  function automatic logic [15:0] seed_fix(input logic [15:0] s);
    return (s == 16'd0) ? SEED_DEFAULT : s;
  endfunction

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [15:0] r_num;
  logic [15:0] r_cnt;
  logic [7:0]  r_warm_cnt;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;

  logic [15:0] w_lfsr_next;
  logic [15:0] w_seed;
  logic [15:0] w_cnt_inc;
  logic        w_hs;

  assign w_lfsr_next = lfsr_step(r_lfsr);
  assign w_seed      = seed_fix(seed_in);
  assign w_cnt_inc   = r_cnt + 16'd1;
  assign w_hs        = r_valid & smp_ready;

  // Run controller, LFSR and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_lfsr     <= SEED_DEFAULT;
      r_num      <= 16'd0;
      r_cnt      <= 16'd0;
      r_warm_cnt <= 8'd0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A same-cycle seed load lands before any warmup step is taken.
          if (seed_load) begin
            r_lfsr <= w_seed;
          end
          if (start) begin
            if (num_samples == 16'd0) begin
              // Empty run: straight to the done pulse, LFSR untouched.
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_num      <= num_samples;
              r_cnt      <= 16'd0;
              r_warm_cnt <= 8'd0;
              r_busy     <= 1'b1;
              if (WARMUP == 0) begin
                r_state <= ST_RUN;
                r_valid <= 1'b1;
              end else begin
                r_state <= ST_WARMUP;
              end
            end
          end
        end

        ST_WARMUP: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_lfsr <= w_lfsr_next;
            if (r_warm_cnt == LP_WARM_LAST) begin
              r_state <= ST_RUN;
              r_valid <= 1'b1;
            end else begin
              r_warm_cnt <= r_warm_cnt + 8'd1;
            end
          end
        end

        ST_RUN: begin
          // Abort wins over a same-cycle handshake: nothing is counted.
          if (abort) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_hs) begin
            r_lfsr <= w_lfsr_next;
            r_cnt  <= w_cnt_inc;
            if (w_cnt_inc == r_num) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign smp_valid  = r_valid;
  assign smp_data   = r_lfsr;
  assign busy       = r_busy;
  assign done       = r_done;
  assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_lfsr_stim_ctrl.sv
// Self-checking bench for lfsr_stim_ctrl: a table of runs checked through an
// expected-sample queue, plus hand-written abort, reset and free-run sequences.
module tb_lfsr_stim_ctrl;

  localparam int unsigned WARMUP = 2;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = 16'd0;
  logic [15:0] num_samples = 16'd0;
  logic        smp_ready = 1'b0;
  logic        smp_valid;
  logic [15:0] smp_data;
  logic        busy;
  logic        done;
  logic [15:0] sample_cnt;

  lfsr_stim_ctrl #(.SEED_DEFAULT(SEED), .WARMUP(WARMUP)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .seed_load(seed_load), .seed_in(seed_in), .num_samples(num_samples),
    .smp_ready(smp_ready), .smp_valid(smp_valid), .smp_data(smp_data),
    .busy(busy), .done(done), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ld;
    logic [15:0] sd;
    logic [15:0] n;
    int          stall_idx;
    int          stall_len;
    logic        chk_first;
    logic [15:0] exp_first;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t        tbl[6];
  logic [15:0] sb_q[$];
  logic [15:0] m_lfsr;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] g_first;
  logic        g_seen;
  logic        g_zero;

  function automatic logic [15:0] m_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0; abort = 1'b0; seed_load = 1'b0; smp_ready = 1'b0;
    adv();
    adv();
    reset = 1'b0;
    m_lfsr = SEED;
    sb_q.delete();
  endtask

  // Start one run, push its expected samples, then drain it through the queue.
  task automatic do_run(input logic ld, input logic [15:0] sd, input logic [15:0] n,
                        input int stall_idx, input int stall_len);
    int cyc = 0;
    int k = 0;
    int rem = stall_len;
    int lat = 0;
    int budget = 4 * int'(n) + stall_len + 50;
    logic got_done = 1'b0;
    g_seen = 1'b0;
    g_first = 16'd0;
    if (ld) m_lfsr = (sd == 16'd0) ? SEED : sd;
    if (n != 16'd0) begin
      for (int i = 0; i < int'(WARMUP); i++) m_lfsr = m_step(m_lfsr);
      for (int i = 0; i < int'(n); i++) begin
        sb_q.push_back(m_lfsr);
        m_lfsr = m_step(m_lfsr);
      end
    end
    seed_load = ld; seed_in = sd; num_samples = n; start = 1'b1; smp_ready = 1'b1;
    adv();
    cyc = 1;
    start = 1'b0; seed_load = 1'b0;
    while (cyc < budget) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (smp_valid) begin
        if (!g_seen) begin
          g_seen = 1'b1;
          g_first = smp_data;
          lat = cyc;
          chk("first_latency", lat, WARMUP + 1);
        end
        if (k == stall_idx && rem > 0) begin
          smp_ready = 1'b0;
          rem--;
          if (sb_q.size() > 0) chk("stall_data", smp_data, sb_q[0]);
          chk("stall_cnt", sample_cnt, k);
        end else begin
          smp_ready = 1'b1;
          if (sb_q.size() > 0) begin
            chk("sample_data", smp_data, sb_q.pop_front());
          end else begin
            chk("sample_unexpected", smp_data, 32'hFFFF_FFFF);
          end
          chk("sample_cnt", sample_cnt, k);
          if (smp_data == 16'd0) g_zero = 1'b1;
          k++;
        end
      end else if (g_seen) begin
        chk("valid_drop", smp_valid, 1'b1);
      end
      adv();
      cyc++;
    end
    chk("done_seen", got_done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("done_valid", smp_valid, 1'b0);
    if (n == 16'd0) begin
      chk("zero_run_latency", cyc, 1);
      chk("zero_run_no_valid", g_seen, 1'b0);
    end
    adv();
    chk("done_single_pulse", done, 1'b0);
    chk("idle_lfsr", smp_data, m_lfsr);
    chk("queue_empty", sb_q.size(), 0);
  endtask

  initial begin
    logic [15:0] exp1;
    logic [15:0] exp2;

    tbl[0] = '{1'b1, 1'b0, 16'h0000, 16'd3, -1, 0, 1'b1, 16'hAB38, 16'd3};
    tbl[1] = '{1'b1, 1'b0, 16'h0000, 16'd3,  1, 4, 1'b1, 16'hAB38, 16'd3};
    tbl[2] = '{1'b0, 1'b0, 16'h0000, 16'd5,  3, 2, 1'b0, 16'h0000, 16'd5};
    tbl[3] = '{1'b0, 1'b1, 16'h0001, 16'd4, -1, 0, 1'b1, 16'h4000, 16'd4};
    tbl[4] = '{1'b0, 1'b1, 16'h0000, 16'd1, -1, 0, 1'b1, 16'hAB38, 16'd1};
    tbl[5] = '{1'b0, 1'b0, 16'h0000, 16'd0, -1, 0, 1'b0, 16'h0000, 16'd0};
    g_zero = 1'b0;

    do_reset();
    chk("rst_valid", smp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_data", smp_data, SEED);
    chk("rst_cnt", sample_cnt, 16'd0);

    for (int r = 0; r < 6; r++) begin
      if (tbl[r].rst) do_reset();
      do_run(tbl[r].ld, tbl[r].sd, tbl[r].n, tbl[r].stall_idx, tbl[r].stall_len);
      if (tbl[r].chk_first) chk($sformatf("row%0d_first", r), g_first, tbl[r].exp_first);
      if (tbl[r].n != 16'd0) chk($sformatf("row%0d_cnt", r), sample_cnt, tbl[r].exp_cnt);
    end

    // Seed load without start, including the zero-seed substitution.
    seed_load = 1'b1; seed_in = 16'h0000;
    adv();
    chk("seed_zero_sub", smp_data, SEED);
    seed_in = 16'h1234;
    adv();
    seed_load = 1'b0;
    chk("seed_load_val", smp_data, 16'h1234);
    chk("seed_load_busy", busy, 1'b0);
    m_lfsr = 16'h1234;

    // Abort after the first handshake; start and seed_load mid-run ignored.
    exp1 = m_step(m_step(m_lfsr));
    exp2 = m_step(exp1);
    start = 1'b1; num_samples = 16'd5; smp_ready = 1'b0;
    adv();
    chk("ab_warm_busy", busy, 1'b1);
    chk("ab_warm_valid", smp_valid, 1'b0);
    start = 1'b1; num_samples = 16'd1;
    adv();
    chk("ab_warm2_valid", smp_valid, 1'b0);
    start = 1'b0; seed_load = 1'b1; seed_in = 16'h5555;
    adv();
    seed_load = 1'b0;
    chk("ab_first_valid", smp_valid, 1'b1);
    chk("ab_first_data", smp_data, exp1);
    smp_ready = 1'b1;
    adv();
    chk("ab_cnt1", sample_cnt, 16'd1);
    chk("ab_second_data", smp_data, exp2);
    abort = 1'b1; start = 1'b1;
    adv();
    abort = 1'b0; start = 1'b0;
    chk("ab_busy", busy, 1'b0);
    chk("ab_valid", smp_valid, 1'b0);
    chk("ab_no_done", done, 1'b0);
    chk("ab_cnt_hold", sample_cnt, 16'd1);
    chk("ab_lfsr_hold", smp_data, exp2);
    adv();
    chk("ab_no_done_later", done, 1'b0);
    chk("ab_idle_busy", busy, 1'b0);
    m_lfsr = exp2;

    // Reset in RUN beats same-cycle start, seed_load and handshake.
    start = 1'b1; num_samples = 16'd4; smp_ready = 1'b1;
    adv();
    start = 1'b0;
    adv();
    adv();
    chk("rr_valid_before", smp_valid, 1'b1);
    adv();
    reset = 1'b1; start = 1'b1; seed_load = 1'b1; seed_in = 16'h1234;
    adv();
    reset = 1'b0; start = 1'b0; seed_load = 1'b0;
    chk("rr_valid", smp_valid, 1'b0);
    chk("rr_busy", busy, 1'b0);
    chk("rr_done", done, 1'b0);
    chk("rr_data", smp_data, SEED);
    chk("rr_cnt", sample_cnt, 16'd0);
    adv();
    chk("rr_no_done", done, 1'b0);
    m_lfsr = SEED;
    sb_q.delete();

    // Full period: 65535 accepted samples return the LFSR to its start point.
    g_zero = 1'b0;
    do_run(1'b0, 16'h0000, 16'hFFFF, -1, 0);
    chk("fr_first", g_first, 16'hAB38);
    chk("fr_cnt", sample_cnt, 16'hFFFF);
    chk("fr_wrap", smp_data, 16'hAB38);
    chk("fr_no_zero", g_zero, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
